// File: rtl/dmem_access_ctrl_pkg.sv
// ============================================================================
// Module : dmem_access_ctrl_pkg
// Brief  : Shared widths, types and configuration for the data-memory access
//          controller. Optional load forwarding is enabled by DMEM_STB_FWD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef RSIZE
`define RSIZE 5
`endif
`ifndef STB_DEPTH
`define STB_DEPTH 2
`endif

package dmem_access_ctrl_pkg;

    localparam int AW        = `MEM_SPACE;
    localparam int DW        = `DSIZE;
    localparam int RW        = `RSIZE;
    localparam int STB_DEPTH = `STB_DEPTH;

    typedef enum logic [1:0] {
        PORT_IDLE  = 2'd0,
        PORT_LOAD  = 2'd1,
        PORT_DRAIN = 2'd2
    } port_sel_e;

endpackage

`default_nettype wire

// File: rtl/dmem_access_ctrl_if.sv
// ============================================================================
// Module : dmem_access_ctrl_if
// Brief  : Request, response and memory-port bundle of the access controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_access_ctrl_if;
    import dmem_access_ctrl_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [RW-1:0] req_rd;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic [RW-1:0] resp_rd;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_write_en;
    logic [DW-1:0] mem_data_out;
    logic          stb_empty;

    // Pipeline and memory side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rd, mem_data_out,
        input  req_ready, resp_valid, resp_rdata, resp_rd,
               mem_address, mem_data_in, mem_write_en, stb_empty
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rd, mem_data_out,
        output req_ready, resp_valid, resp_rdata, resp_rd,
               mem_address, mem_data_in, mem_write_en, stb_empty
    );

endinterface

`default_nettype wire

// File: rtl/dmem_access_ctrl_store_buffer.sv
// ============================================================================
// Module : dmem_access_ctrl_store_buffer
// Brief  : In-order posted-store FIFO with a parallel address lookup that
//          returns the data of the youngest matching entry.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl_store_buffer #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          hit_o,
    output logic [DW-1:0] hit_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: validity is carried by count/pointers.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module : dmem_access_ctrl
// Brief  : MEM-stage data-memory initiator: loads take the port with a fixed
//          1-cycle response, stores are posted and drained in idle cycles.
//          Define DMEM_STB_FWD_EN to forward buffered store data to loads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave bus
);

    logic          w_stb_full;
    logic          w_stb_empty;
    logic          w_stb_hit;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic [DW-1:0] w_hit_data;
    logic          w_load_ok;
    logic          w_load_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_fwd;
    port_sel_e     w_sel;

    logic          resp_valid_q, resp_valid_d;
    logic [RW-1:0] resp_rd_q,    resp_rd_d;
    logic          fwd_hit_q,    fwd_hit_d;
    logic [DW-1:0] fwd_data_q,   fwd_data_d;

    dmem_access_ctrl_store_buffer #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (STB_DEPTH)
    ) u_stb (
        .clk           (clk),
        .rst           (rst),
        .push_i        (w_push),
        .push_addr_i   (bus.req_addr),
        .push_data_i   (bus.req_wdata),
        .pop_i         (w_pop),
        .full_o        (w_stb_full),
        .empty_o       (w_stb_empty),
        .head_addr_o   (w_head_addr),
        .head_data_o   (w_head_data),
        .lookup_addr_i (bus.req_addr),
        .hit_o         (w_stb_hit),
        .hit_data_o    (w_hit_data)
    );

    // A full buffer blocks loads, which guarantees a drain that same cycle.
    always_comb begin
`ifdef DMEM_STB_FWD_EN
        w_load_ok = !rst && !w_stb_full;
        w_fwd     = w_stb_hit;
`else
        w_load_ok = !rst && !w_stb_full && !w_stb_hit;
        w_fwd     = 1'b0;
`endif
        w_load_fire   = bus.req_valid && !bus.req_we && w_load_ok;
        w_push        = bus.req_valid &&  bus.req_we && !rst;
        bus.req_ready = rst ? 1'b0 : (bus.req_we ? 1'b1 : w_load_ok);
    end

    always_comb begin
        w_sel = PORT_IDLE;
        if (w_load_fire) begin
            w_sel = PORT_LOAD;
        end else if (!w_stb_empty) begin
            w_sel = PORT_DRAIN;
        end
    end

    assign w_pop = (w_sel == PORT_DRAIN);

    always_comb begin
        bus.mem_address  = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = 1'b0;
        unique case (w_sel)
            PORT_LOAD: begin
                bus.mem_address = bus.req_addr;
            end
            PORT_DRAIN: begin
                bus.mem_address  = w_head_addr;
                bus.mem_data_in  = w_head_data;
                bus.mem_write_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        resp_valid_d = w_load_fire;
        resp_rd_d    = resp_rd_q;
        fwd_hit_d    = fwd_hit_q;
        fwd_data_d   = fwd_data_q;
        if (w_load_fire) begin
            resp_rd_d  = bus.req_rd;
            fwd_hit_d  = w_fwd;
            fwd_data_d = w_hit_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_rd_q    <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_rd_q    <= resp_rd_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    // Memory read data arrives in the response cycle; forwarded data was captured.
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_rdata = resp_valid_q ? (fwd_hit_q ? fwd_data_q : bus.mem_data_out) : '0;
    assign bus.stb_empty  = w_stb_empty;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module : tb_dmem_access_ctrl
// Brief  : Self-checking bench: directed scenarios plus random traffic against
//          a queue-based reference model and a registered-read memory model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

`ifdef DMEM_STB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int MEMN = 1 << AW;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return DW'(32'h1234);
        return DW'(32'h1000 + i * 7);
    endfunction

    // Memory with registered read data.
    logic          mem_init;
    logic [DW-1:0] mem_arr [MEMN];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEMN; i++) mem_arr[i] <= init_val(i);
        end else if (bus.mem_write_en) begin
            mem_arr[bus.mem_address] <= bus.mem_data_in;
        end
        bus.mem_data_out <= mem_arr[bus.mem_address];
    end

    // Reference model state.
    st_t           stq[$];
    logic [DW-1:0] ref_mem [MEMN];
    bit            pend_v;
    logic [DW-1:0] pend_d;
    logic [RW-1:0] pend_rd;
    bit            m_ld, m_push, m_drain;
    logic [DW-1:0] m_ld_d;
    logic [RW-1:0] m_ld_rd;
    st_t           m_st;
    logic          exp_ready, exp_mwe, exp_rvalid, exp_empty;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mdin, exp_rdata;
    logic [RW-1:0] exp_rd;

    task automatic model_reset();
        stq.delete();
        pend_v  = 1'b0;
        pend_d  = '0;
        pend_rd = '0;
        m_ld    = 1'b0;
        m_push  = 1'b0;
        m_drain = 1'b0;
    endtask

    // Expected outputs for the current cycle from the current inputs and queue.
    task automatic eval();
        bit            full, match, ld_ok;
        logic [DW-1:0] yd;
        full  = (stq.size() == STB_DEPTH);
        match = 1'b0;
        yd    = '0;
        foreach (stq[i]) begin
            if (stq[i].a == bus.req_addr) begin
                match = 1'b1;
                yd    = stq[i].d;
            end
        end
        ld_ok     = !rst && !full && (FWD || !match);
        exp_ready = rst ? 1'b0 : (bus.req_we ? 1'b1 : ld_ok);
        m_ld      = bus.req_valid && !bus.req_we && ld_ok;
        m_push    = !rst && bus.req_valid && bus.req_we;
        m_drain   = !rst && !m_ld && (stq.size() > 0);
        m_st.a    = bus.req_addr;
        m_st.d    = bus.req_wdata;
        m_ld_rd   = bus.req_rd;
        m_ld_d    = (FWD && match) ? yd : ref_mem[bus.req_addr];
        exp_mwe   = 1'b0;
        exp_maddr = '0;
        exp_mdin  = '0;
        if (m_ld) begin
            exp_maddr = bus.req_addr;
        end else if (m_drain) begin
            exp_mwe   = 1'b1;
            exp_maddr = stq[0].a;
            exp_mdin  = stq[0].d;
        end
        exp_rvalid = pend_v;
        exp_rdata  = pend_v ? pend_d : '0;
        exp_rd     = pend_rd;
        exp_empty  = (stq.size() == 0);
    endtask

    task automatic commit();
        if (m_drain) begin
            ref_mem[stq[0].a] = stq[0].d;
            void'(stq.pop_front());
        end
        if (m_push) stq.push_back(m_st);
        pend_v = m_ld;
        if (m_ld) begin
            pend_d  = m_ld_d;
            pend_rd = m_ld_rd;
        end
    endtask

    // One clock cycle: advance model at the edge, drive, predict, sample at negedge.
    task automatic step(input bit v, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [RW-1:0] rd);
        @(posedge clk);
        commit();
        #1;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_rd    = rd;
        eval();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%0b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== '0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", bus.resp_rdata); end
        checks++; if (bus.resp_rd !== '0) begin failures++; $display("FAIL rst_rd got=%0h exp=0", bus.resp_rd); end
        checks++; if (bus.stb_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", bus.stb_empty); end
        checks++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL rst_mwe got=%0b exp=0", bus.mem_write_en); end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        eval();
    endtask

    task automatic test_load();
        step(1'b1, 1'b0, AW'('h05), '0, RW'(3));
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ld_ready got=%0b exp=1", bus.req_ready); end
        checks++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL ld_mwe got=%0b exp=0", bus.mem_write_en); end
        checks++; if (bus.mem_address !== AW'('h05)) begin failures++; $display("FAIL ld_maddr got=%0h exp=05", bus.mem_address); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL ld_rvalid_early got=%0b exp=0", bus.resp_valid); end
        idle();
        checks++; if (bus.resp_valid !== 1'b1) begin failures++; $display("FAIL ld_rvalid got=%0b exp=1", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== DW'('h1234)) begin failures++; $display("FAIL ld_rdata got=%0h exp=1234", bus.resp_rdata); end
        checks++; if (bus.resp_rd !== RW'(3)) begin failures++; $display("FAIL ld_rd got=%0h exp=3", bus.resp_rd); end
        idle();
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL ld_rvalid_after got=%0b exp=0", bus.resp_valid); end
    endtask

    task automatic test_store_drain();
        step(1'b1, 1'b1, AW'('h0A), DW'('hBEEF), '0);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL st_ready got=%0b exp=1", bus.req_ready); end
        checks++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL st_mwe_early got=%0b exp=0", bus.mem_write_en); end
        idle();
        checks++; if (bus.stb_empty !== 1'b0) begin failures++; $display("FAIL st_empty got=%0b exp=0", bus.stb_empty); end
        checks++; if (bus.mem_write_en !== 1'b1) begin failures++; $display("FAIL st_mwe got=%0b exp=1", bus.mem_write_en); end
        checks++; if (bus.mem_address !== AW'('h0A)) begin failures++; $display("FAIL st_maddr got=%0h exp=0a", bus.mem_address); end
        checks++; if (bus.mem_data_in !== DW'('hBEEF)) begin failures++; $display("FAIL st_mdin got=%0h exp=beef", bus.mem_data_in); end
        idle();
        checks++; if (bus.stb_empty !== 1'b1) begin failures++; $display("FAIL st_empty_after got=%0b exp=1", bus.stb_empty); end
        checks++; if (bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL st_mwe_after got=%0b exp=0", bus.mem_write_en); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b1, AW'('h01), DW'('h00A1), '0);
        step(1'b1, 1'b1, AW'('h02), DW'('h00A2), '0);
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_address !== AW'('h01)) begin failures++; $display("FAIL b2b_drain1 got=%0b/%0h exp=1/01", bus.mem_write_en, bus.mem_address); end
        checks++; if (bus.mem_data_in !== DW'('h00A1)) begin failures++; $display("FAIL b2b_drain1_data got=%0h exp=a1", bus.mem_data_in); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, AW'('h10 + i), '0, RW'(i));
            checks++; if (bus.req_ready !== 1'b1 || bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL b2b_ld%0d ready/mwe got=%0b/%0b exp=1/0", i, bus.req_ready, bus.mem_write_en); end
            checks++; if (bus.mem_address !== AW'('h10 + i)) begin failures++; $display("FAIL b2b_ld%0d maddr got=%0h exp=%0h", i, bus.mem_address, 'h10 + i); end
            if (i > 0) begin
                checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== init_val('h10 + i - 1)) begin failures++; $display("FAIL b2b_resp%0d got=%0b/%0h exp=1/%0h", i, bus.resp_valid, bus.resp_rdata, init_val('h10 + i - 1)); end
            end
        end
        idle();
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_address !== AW'('h02) || bus.mem_data_in !== DW'('h00A2)) begin failures++; $display("FAIL b2b_drain2 got=%0b/%0h/%0h exp=1/02/a2", bus.mem_write_en, bus.mem_address, bus.mem_data_in); end
        checks++; if (bus.resp_rdata !== init_val('h13)) begin failures++; $display("FAIL b2b_resp3 got=%0h exp=%0h", bus.resp_rdata, init_val('h13)); end
        idle();
        checks++; if (bus.stb_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%0b exp=1", bus.stb_empty); end
    endtask

    task automatic test_hazard();
        step(1'b1, 1'b1, AW'('h07), DW'('h00AA), '0);
        step(1'b1, 1'b0, AW'('h07), '0, RW'(4));
`ifdef DMEM_STB_FWD_EN
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_write_en !== 1'b0) begin failures++; $display("FAIL hz_fwd_accept got=%0b/%0b exp=1/0", bus.req_ready, bus.mem_write_en); end
`else
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL hz_block got=%0b exp=0", bus.req_ready); end
        checks++; if (bus.mem_write_en !== 1'b1 || bus.mem_data_in !== DW'('h00AA)) begin failures++; $display("FAIL hz_drain got=%0b/%0h exp=1/aa", bus.mem_write_en, bus.mem_data_in); end
        step(1'b1, 1'b0, AW'('h07), '0, RW'(4));
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL hz_retry got=%0b exp=1", bus.req_ready); end
`endif
        idle();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== DW'('h00AA) || bus.resp_rd !== RW'(4)) begin failures++; $display("FAIL hz_resp got=%0b/%0h/%0h exp=1/aa/4", bus.resp_valid, bus.resp_rdata, bus.resp_rd); end
        idle();
    endtask

    task automatic test_youngest();
        step(1'b1, 1'b1, AW'('h07), DW'(1), '0);
        step(1'b1, 1'b1, AW'('h07), DW'(2), '0);
        step(1'b1, 1'b0, AW'('h07), '0, RW'(6));
`ifndef DMEM_STB_FWD_EN
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL yg_block got=%0b exp=0", bus.req_ready); end
        step(1'b1, 1'b0, AW'('h07), '0, RW'(6));
`endif
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL yg_accept got=%0b exp=1", bus.req_ready); end
        idle();
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== DW'(2)) begin failures++; $display("FAIL yg_resp got=%0b/%0h exp=1/2", bus.resp_valid, bus.resp_rdata); end
        idle();
    endtask

    task automatic test_reset_in_flight();
        step(1'b1, 1'b1, AW'('h20), DW'('h5555), '0);
        step(1'b1, 1'b0, AW'('h21), '0, RW'(9));
        @(posedge clk);
        commit();
        #1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rif_rvalid got=%0b exp=0", bus.resp_valid); end
        checks++; if (bus.stb_empty !== 1'b1) begin failures++; $display("FAIL rif_empty got=%0b exp=1", bus.stb_empty); end
        @(negedge clk);
        rst = 1'b0;
        eval();
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++; if (bus.mem_write_en !== 1'b0 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rif_quiet%0d got=%0b/%0b exp=0/0", i, bus.mem_write_en, bus.resp_valid); end
        end
        step(1'b1, 1'b0, AW'('h20), '0, RW'(1));
        idle();
        checks++; if (bus.resp_rdata !== init_val('h20)) begin failures++; $display("FAIL rif_discard got=%0h exp=%0h", bus.resp_rdata, init_val('h20)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 DW'($urandom), RW'($urandom));
            checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, bus.req_ready, exp_ready); end
            checks++; if (bus.mem_write_en !== exp_mwe) begin failures++; $display("FAIL rnd_mwe n=%0d got=%0b exp=%0b", n, bus.mem_write_en, exp_mwe); end
            checks++; if (bus.mem_address !== exp_maddr) begin failures++; $display("FAIL rnd_maddr n=%0d got=%0h exp=%0h", n, bus.mem_address, exp_maddr); end
            checks++; if (bus.mem_data_in !== exp_mdin) begin failures++; $display("FAIL rnd_mdin n=%0d got=%0h exp=%0h", n, bus.mem_data_in, exp_mdin); end
            checks++; if (bus.resp_valid !== exp_rvalid) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%0b exp=%0b", n, bus.resp_valid, exp_rvalid); end
            checks++; if (bus.resp_rdata !== exp_rdata) begin failures++; $display("FAIL rnd_rdata n=%0d got=%0h exp=%0h", n, bus.resp_rdata, exp_rdata); end
            checks++; if (bus.stb_empty !== exp_empty) begin failures++; $display("FAIL rnd_empty n=%0d got=%0b exp=%0b", n, bus.stb_empty, exp_empty); end
            if (exp_rvalid) begin
                checks++; if (bus.resp_rd !== exp_rd) begin failures++; $display("FAIL rnd_rd n=%0d got=%0h exp=%0h", n, bus.resp_rd, exp_rd); end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_rd    = '0;
        for (int i = 0; i < MEMN; i++) ref_mem[i] = init_val(i);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        test_reset();
        test_load();
        test_store_drain();
        test_back_to_back();
        test_hazard();
        test_youngest();
        test_reset_in_flight();
        test_random();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
